// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: drives the PLL reset, waits for and qualifies lock with timeout and
// bounded retry, then releases the fabric system reset. A loss of lock in RUN is counted and
// restarts the whole PLL reset sequence.
// Build option: define PLL_SUP_DEBOUNCE_EN to ignore loss-of-lock dropouts in RUN shorter
// than DEBOUNCE_CYCLES consecutive cycles.
module pll_lock_supervisor #(
  parameter int unsigned RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT    = 65536,
  parameter int unsigned STABLE_CYCLES   = 1024,
  parameter int unsigned MAX_RETRY       = 3,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                           refclk_i,
  input  logic                           rst_i,
  input  logic                           locked_i,
  output logic                           pll_rst_o,
  output logic                           sys_rst_o,
  output logic                           lock_ok_o,
  output logic                           fail_o,
  output logic [$clog2(MAX_RETRY+1):0]   retry_count_o,
  output logic [CNT_W-1:0]               loss_count_o
);

  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1) + 1;
  localparam int unsigned MaxAB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MaxABC = (MaxAB > STABLE_CYCLES) ? MaxAB : STABLE_CYCLES;
  // The shared counter also times the debounce window, so it covers that length too.
  localparam int unsigned MaxCnt = (MaxABC > DEBOUNCE_CYCLES) ? MaxABC : DEBOUNCE_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0]   RstLast     = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0]   TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0]   StableLast  = CntW'(STABLE_CYCLES - 1);
  localparam logic [RetryW-1:0] MaxRetry    = RetryW'(MAX_RETRY);
`ifdef PLL_SUP_DEBOUNCE_EN
  localparam logic [CntW-1:0]   DebLast     = CntW'(DEBOUNCE_CYCLES - 1);
`endif

  typedef enum logic [2:0] {StPllRst, StWaitLock, StStable, StRun, StFail} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic [CNT_W-1:0]    loss_q, loss_d;
  logic                sync1_q, sync2_q;
  logic                pll_rst_q, pll_rst_d;
  logic                sys_rst_q, sys_rst_d;
  logic                lock_ok_q, lock_ok_d;
  logic                fail_q, fail_d;
  logic                locked_s;

  assign locked_s = sync2_q;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= locked_i;
      sync2_q <= sync1_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      state_q   <= StPllRst;
      cnt_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      lock_ok_q <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      lock_ok_q <= lock_ok_d;
      fail_q    <= fail_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    unique case (state_q)
      StPllRst: begin
        if (cnt_q == RstLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitLock: begin
        // Lock takes priority over a coincident timeout.
        if (locked_s) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          cnt_d = '0;
          if (retry_q == MaxRetry) begin
            state_d = StFail;
          end else begin
            retry_d = retry_q + RetryW'(1);
            state_d = StPllRst;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStable: begin
        if (!locked_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
`ifdef PLL_SUP_DEBOUNCE_EN
        // cnt holds the length of the current run of lost-lock cycles.
        if (locked_s) begin
          cnt_d = '0;
        end else if (cnt_q == DebLast) begin
          state_d = StPllRst;
          cnt_d   = '0;
          if (loss_q != '1) loss_d = loss_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`else
        if (!locked_s) begin
          state_d = StPllRst;
          cnt_d   = '0;
          if (loss_q != '1) loss_d = loss_q + CNT_W'(1);
        end
`endif
      end
      StFail: begin
        state_d = StFail;
      end
      default: begin
        state_d = StPllRst;
        cnt_d   = '0;
      end
    endcase

    pll_rst_d = (state_d == StPllRst) || (state_d == StFail);
    sys_rst_d = (state_d != StRun);
    lock_ok_d = (state_d == StRun);
    fail_d    = (state_d == StFail);
  end

  assign pll_rst_o     = pll_rst_q;
  assign sys_rst_o     = sys_rst_q;
  assign lock_ok_o     = lock_ok_q;
  assign fail_o        = fail_q;
  assign retry_count_o = retry_q;
  assign loss_count_o  = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: hand-derived vector table, directed multi-cycle sequences,
// and a randomized lock stream checked against a timestamp/history based reference model.
module tb_pll_lock_supervisor;

  localparam int RST_C   = 4;
  localparam int TO_C    = 20;
  localparam int STB_C   = 8;
  localparam int MAXR    = 2;
  localparam int CNT_W   = 2;
  localparam int DEB_C   = 3;
  localparam int RW      = $clog2(MAXR + 1) + 1;
  localparam int LOSSMAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             lk  = 1'b0;
  logic             pll_rst, sys_rst, lock_ok, fail;
  logic [RW-1:0]    retry_count;
  logic [CNT_W-1:0] loss_count;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .RST_CYCLES      (RST_C),
    .LOCK_TIMEOUT    (TO_C),
    .STABLE_CYCLES   (STB_C),
    .MAX_RETRY       (MAXR),
    .CNT_W           (CNT_W),
    .DEBOUNCE_CYCLES (DEB_C)
  ) dut (
    .refclk_i      (clk),
    .rst_i         (rst),
    .locked_i      (lk),
    .pll_rst_o     (pll_rst),
    .sys_rst_o     (sys_rst),
    .lock_ok_o     (lock_ok),
    .fail_o        (fail),
    .retry_count_o (retry_count),
    .loss_count_o  (loss_count)
  );

  // {pll_rst, sys_rst, lock_ok, fail, retry_count, loss_count}
  typedef logic [RW+CNT_W+3:0] outv_t;

  int total = 0;
  int bad   = 0;

  function automatic outv_t mk(input bit p, input bit s, input bit o, input bit f,
                               input int r, input int l);
    logic [RW-1:0]    rv;
    logic [CNT_W-1:0] lv;
    rv = RW'(r);
    lv = CNT_W'(l);
    return {p, s, o, f, rv, lv};
  endfunction

  function automatic outv_t act();
    return {pll_rst, sys_rst, lock_ok, fail, retry_count, loss_count};
  endfunction

  task automatic check(input string name, input outv_t a, input outv_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %b want %b (pll,sys,ok,fail,retry,loss) t=%0t", name, a, e, $time);
    end
  endtask

  task automatic check_int(input string name, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d t=%0t", name, a, e, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases: 0 pll reset, 1 waiting for lock, 2 qualifying, 3 running, 4 failed.
  int   m_phase, m_cyc, m_enter, m_retry, m_loss;
  logic pin_q[$];
  logic ls_q[$];

  task automatic enter_phase(input int p);
    m_phase = p;
    m_enter = m_cyc + 1;
  endtask

  task automatic lose();
    if (m_loss < LOSSMAX) m_loss++;
    enter_phase(0);
  endtask

  task automatic model_step(input logic r, input logic pin);
    logic ls;
    int   el;
`ifdef PLL_SUP_DEBOUNCE_EN
    int   zeros;
`endif
    if (r) begin
      m_phase = 0; m_cyc = 0; m_enter = 1; m_retry = 0; m_loss = 0;
      pin_q.delete();
      pin_q.push_back(1'b0);
      pin_q.push_back(1'b0);
      ls_q.delete();
      return;
    end
    m_cyc++;
    ls = pin_q[pin_q.size() - 2];  // pin value from two edges ago
    pin_q.push_back(pin);
    if (pin_q.size() > 4) void'(pin_q.pop_front());
    ls_q.push_back(ls);
    if (ls_q.size() > 32) void'(ls_q.pop_front());
    el = m_cyc - m_enter + 1;      // cycles spent in the phase, this one included
    case (m_phase)
      0: if (el >= RST_C) enter_phase(1);
      1: begin
        if (ls) enter_phase(2);
        else if (el >= TO_C) begin
          if (m_retry < MAXR) begin
            m_retry++;
            enter_phase(0);
          end else enter_phase(4);
        end
      end
      2: begin
        if (!ls) enter_phase(1);
        else if (el >= STB_C) begin
          m_retry = 0;
          enter_phase(3);
        end
      end
      3: begin
`ifdef PLL_SUP_DEBOUNCE_EN
        zeros = 0;
        for (int i = ls_q.size() - 1; i >= 0; i--) begin
          if (ls_q[i]) break;
          zeros++;
        end
        if (zeros >= DEB_C && el >= DEB_C) lose();
`else
        if (!ls) lose();
`endif
      end
      default: ;
    endcase
  endtask

  function automatic outv_t m_exp();
    return mk(m_phase == 0 || m_phase == 4, m_phase != 3, m_phase == 3, m_phase == 4,
              m_retry, m_loss);
  endfunction

  // One clock: drive at negedge, model at posedge, return at next negedge for sampling.
  task automatic cyc(input logic r, input logic pin);
    rst = r;
    lk  = pin;
    @(posedge clk);
    model_step(r, pin);
    @(negedge clk);
  endtask

  // ---------------- directed helpers ----------------
  task automatic bring_up();
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 13; i++) cyc(1'b0, 1'b1);
    check("bring_up_run", act(), mk(0, 0, 1, 0, 0, 0));
  endtask

  // From RUN: zlen cycles of lost lock, then check loss handling and full recovery timing.
  task automatic loss_seq(input int zlen, input int exp_loss);
    int w;
    int n;
    for (int i = 0; i < zlen; i++) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    check("loss_enter", act(), mk(1, 1, 0, 0, 0, exp_loss));
    w = 1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1);
      if (pll_rst) w++;
      else break;
    end
    check_int("loss_pll_pulse_width", w, RST_C);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1'b0, 1'b1);
      n++;
      if (lock_ok) break;
    end
    check_int("loss_recover_cycles", n, STB_C + 1);
    check("loss_recovered", act(), mk(0, 0, 1, 0, 0, exp_loss));
  endtask

  typedef struct {
    logic  r;
    logic  pin;
    int    n;
    outv_t e;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   w;
    bit   ok_all;
    bit   p;
    int   len;
    bit   r;

    @(negedge clk);

    // Bring-up with lock present, a one-cycle RUN dropout, then a never-locking PLL.
    vecs.push_back('{1'b1, 1'b1, 1,  mk(1, 1, 0, 0, 0, 0)});
    vecs.push_back('{1'b0, 1'b1, 3,  mk(1, 1, 0, 0, 0, 0)});
    vecs.push_back('{1'b0, 1'b1, 1,  mk(0, 1, 0, 0, 0, 0)});
    vecs.push_back('{1'b0, 1'b1, 1,  mk(0, 1, 0, 0, 0, 0)});
    vecs.push_back('{1'b0, 1'b1, 7,  mk(0, 1, 0, 0, 0, 0)});
    vecs.push_back('{1'b0, 1'b1, 1,  mk(0, 0, 1, 0, 0, 0)});
    vecs.push_back('{1'b0, 1'b0, 1,  mk(0, 0, 1, 0, 0, 0)});
    vecs.push_back('{1'b0, 1'b1, 1,  mk(0, 0, 1, 0, 0, 0)});
`ifdef PLL_SUP_DEBOUNCE_EN
    vecs.push_back('{1'b0, 1'b1, 1,  mk(0, 0, 1, 0, 0, 0)});
`else
    vecs.push_back('{1'b0, 1'b1, 1,  mk(1, 1, 0, 0, 0, 1)});
`endif
    vecs.push_back('{1'b1, 1'b0, 1,  mk(1, 1, 0, 0, 0, 0)});
    vecs.push_back('{1'b0, 1'b0, 4,  mk(0, 1, 0, 0, 0, 0)});
    vecs.push_back('{1'b0, 1'b0, 19, mk(0, 1, 0, 0, 0, 0)});
    vecs.push_back('{1'b0, 1'b0, 1,  mk(1, 1, 0, 0, 1, 0)});
    vecs.push_back('{1'b0, 1'b0, 3,  mk(1, 1, 0, 0, 1, 0)});
    vecs.push_back('{1'b0, 1'b0, 1,  mk(0, 1, 0, 0, 1, 0)});
    vecs.push_back('{1'b0, 1'b0, 19, mk(0, 1, 0, 0, 1, 0)});
    vecs.push_back('{1'b0, 1'b0, 1,  mk(1, 1, 0, 0, 2, 0)});
    vecs.push_back('{1'b0, 1'b0, 24, mk(1, 1, 0, 1, 2, 0)});
    vecs.push_back('{1'b0, 1'b1, 40, mk(1, 1, 0, 1, 2, 0)});
    vecs.push_back('{1'b1, 1'b1, 1,  mk(1, 1, 0, 0, 0, 0)});

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].n; k++) cyc(vecs[i].r, vecs[i].pin);
      check($sformatf("vec%0d", i), act(), vecs[i].e);
    end

    // Lock dropout during qualification after 5 good cycles forces a full requalification.
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    ok_all = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1);
      if (!sys_rst || lock_ok) ok_all = 1'b0;
    end
    check_int("stable_requal_no_early_run", int'(ok_all), 1);
    cyc(1'b0, 1'b1);
    check("stable_requal_run", act(), mk(0, 0, 1, 0, 0, 0));

    // Loss of lock in RUN, loss_count saturating at all-ones.
    bring_up();
`ifdef PLL_SUP_DEBOUNCE_EN
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    ok_all = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1);
      if (act() !== mk(0, 0, 1, 0, 0, 0)) ok_all = 1'b0;
    end
    check_int("short_dropout_ignored", int'(ok_all), 1);
    for (int k = 1; k <= 4; k++) loss_seq(DEB_C, (k < LOSSMAX) ? k : LOSSMAX);
`else
    for (int k = 1; k <= 4; k++) loss_seq(1, (k < LOSSMAX) ? k : LOSSMAX);
`endif

    // Reset in RUN (loss_count nonzero) and in WAIT_LOCK mid-count.
    cyc(1'b1, 1'b1);
    check("rst_in_run", act(), mk(1, 1, 0, 0, 0, 0));
    for (int i = 0; i < RST_C + 10; i++) cyc(1'b0, 1'b0);
    check("wait_mid_count", act(), mk(0, 1, 0, 0, 0, 0));
    cyc(1'b1, 1'b0);
    check("rst_in_wait", act(), mk(1, 1, 0, 0, 0, 0));
    w = 1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0);
      if (pll_rst) w++;
      else break;
    end
    check_int("pll_pulse_after_rst", w, RST_C);

    // Randomized lock stream against the reference model.
    cyc(1'b1, 1'b1);
    check("rand_reset", act(), m_exp());
    for (int s = 0; s < 220; s++) begin
      p = 1'($urandom_range(0, 1));
      if (p) len = $urandom_range(1, 30);
      else if ($urandom_range(0, 1) == 0) len = $urandom_range(1, 4);
      else len = $urandom_range(5, 24);
      r = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < len; k++) begin
        cyc(r && (k == 0), p);
        check("rand_model", act(), m_exp());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
